// File: rtl/osd_wr_arbiter_if.sv
// Bundles the host byte stream, the core popup handshake and the buffer write port of osd_wr_arbiter.
interface osd_wr_arbiter_if #(
    parameter int ADDR_W = 11
);
    logic              host_ss;
    logic              host_valid;
    logic              host_first;
    logic [7:0]        host_data;
    logic              msg_start;
    logic [3:0]        msg_line;
    logic              msg_valid;
    logic [7:0]        msg_data;
    logic              msg_ready;
    logic              msg_busy;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_wdata;

    modport master (
        output host_ss, host_valid, host_first, host_data,
        output msg_start, msg_line, msg_valid, msg_data,
        input  msg_ready, msg_busy, buf_we, buf_addr, buf_wdata
    );

    modport slave (
        input  host_ss, host_valid, host_first, host_data,
        input  msg_start, msg_line, msg_valid, msg_data,
        output msg_ready, msg_busy, buf_we, buf_addr, buf_wdata
    );
endinterface

// File: rtl/osd_wr_arbiter.sv
// OSD buffer write-port owner: decodes the host byte stream, merges core popup writes
// (host always wins the port) and keeps the OSD enabled for a number of frames after a popup.
module osd_wr_arbiter #(
    parameter logic       BIG_OSD      = 1'b0,
    parameter logic [7:0] POPUP_FRAMES = 8'd100
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    osd_wr_arbiter_if.slave bus,
    input  logic            vs_in,
    output logic            osd_enable
);
    localparam int ADDR_W = BIG_OSD ? 12 : 11;
    localparam int LINE_W = ADDR_W - 8;

    typedef enum logic [1:0] {H_IDLE, H_WR, H_SKIP} hstate_t;
    typedef enum logic       {C_IDLE, C_WR}         cstate_t;

    hstate_t           h_state, h_next;
    cstate_t           c_state, c_next;
    logic [LINE_W-1:0] host_line, core_line;
    logic [7:0]        host_byte, core_cnt;
    logic              host_en, host_en_next;
    logic [7:0]        popup_cnt, popup_next;
    logic              vs_d;
    logic              host_cmd, wr_cmd, en_cmd;
    logic              host_wr, core_wr, vs_rise;

    assign bus.msg_busy = (c_state == C_WR);

    always_comb begin
        h_next        = h_state;
        c_next        = c_state;
        host_wr       = 1'b0;
        core_wr       = 1'b0;
        host_en_next  = host_en;
        popup_next    = popup_cnt;
        bus.msg_ready = 1'b0;
        host_cmd      = bus.host_valid & bus.host_first & ~bus.host_ss;
        wr_cmd        = host_cmd & (bus.host_data[7:4] == 4'h2);
        en_cmd        = host_cmd & (bus.host_data[7:4] == 4'h4);
        vs_rise       = vs_in & ~vs_d;

        if (bus.host_ss) begin
            h_next = H_IDLE;
        end else if (wr_cmd) begin
            h_next = H_WR;
        end else if (en_cmd) begin
            h_next       = H_IDLE;
            host_en_next = bus.host_data[0];
        end else if (host_cmd) begin
            h_next = H_SKIP;
        end else if (bus.host_valid && h_state == H_WR) begin
            host_wr = 1'b1;
        end

        // The core only sees the port on cycles the host is not writing.
        bus.msg_ready = (c_state == C_WR) && !host_wr;
        if (bus.msg_start) begin
            c_next = C_WR;
        end else if (bus.msg_ready && bus.msg_valid) begin
            core_wr = 1'b1;
            if (core_cnt == 8'hFF) c_next = C_IDLE;
        end

        // Later assignments take priority: disable over load over frame decrement.
        if (vs_rise && popup_cnt != 8'd0) popup_next = popup_cnt - 8'd1;
        if (core_wr && core_cnt == 8'hFF) popup_next = POPUP_FRAMES;
        if (en_cmd && !bus.host_data[0]) popup_next = 8'd0;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            h_state       <= H_IDLE;
            c_state       <= C_IDLE;
            host_line     <= '0;
            host_byte     <= 8'd0;
            core_line     <= '0;
            core_cnt      <= 8'd0;
            host_en       <= 1'b0;
            popup_cnt     <= 8'd0;
            vs_d          <= 1'b0;
            osd_enable    <= 1'b0;
            bus.buf_we    <= 1'b0;
            bus.buf_addr  <= '0;
            bus.buf_wdata <= 8'd0;
        end else begin
            h_state    <= h_next;
            c_state    <= c_next;
            host_en    <= host_en_next;
            popup_cnt  <= popup_next;
            vs_d       <= vs_in;
            osd_enable <= host_en_next | (popup_next != 8'd0);
            bus.buf_we <= host_wr | core_wr;

            if (wr_cmd) begin
                host_line <= bus.host_data[LINE_W-1:0];
                host_byte <= 8'd0;
            end
            if (bus.msg_start) begin
                core_line <= bus.msg_line[LINE_W-1:0];
                core_cnt  <= 8'd0;
            end else if (core_wr) begin
                core_cnt <= core_cnt + 8'd1;
            end

            // Byte pointers are 8 bits, so writes past the end wrap to the line start.
            if (host_wr) begin
                bus.buf_addr  <= {host_line, host_byte};
                bus.buf_wdata <= bus.host_data;
                host_byte     <= host_byte + 8'd1;
            end else if (core_wr) begin
                bus.buf_addr  <= {core_line, core_cnt};
                bus.buf_wdata <= bus.msg_data;
            end
        end
    end
endmodule

// File: tb/tb_osd_wr_arbiter.sv
// Randomized self-checking bench for osd_wr_arbiter (BIG_OSD=0, POPUP_FRAMES=3).
module tb_osd_wr_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vs = 1'b0;
    logic osd;
    int   checks = 0;
    int   failures = 0;
    logic [18:0] wq[$];

    always #5 clk = ~clk;

    osd_wr_arbiter_if #(.ADDR_W(11)) bus();

    osd_wr_arbiter #(.BIG_OSD(1'b0), .POPUP_FRAMES(8'd3)) dut (
        .clk_sys(clk), .reset_n(rst_n), .bus(bus), .vs_in(vs), .osd_enable(osd)
    );

    always @(negedge clk) if (bus.buf_we === 1'b1) wq.push_back({bus.buf_addr, bus.buf_wdata});

    task automatic host_byte(input logic first, input logic [7:0] d);
        bus.host_first = first;
        bus.host_data  = d;
        bus.host_valid = 1'b1;
        @(posedge clk); #1;
        bus.host_valid = 1'b0;
        bus.host_first = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 6;
        if (bus.buf_we !== 1'b0) begin failures++; $display("FAIL reset_buf_we got=%b exp=0", bus.buf_we); end
        if (bus.buf_addr !== 11'd0) begin failures++; $display("FAIL reset_buf_addr got=%h exp=0", bus.buf_addr); end
        if (bus.buf_wdata !== 8'd0) begin failures++; $display("FAIL reset_buf_wdata got=%h exp=0", bus.buf_wdata); end
        if (bus.msg_ready !== 1'b0) begin failures++; $display("FAIL reset_msg_ready got=%b exp=0", bus.msg_ready); end
        if (bus.msg_busy !== 1'b0) begin failures++; $display("FAIL reset_msg_busy got=%b exp=0", bus.msg_busy); end
        if (osd !== 1'b0) begin failures++; $display("FAIL reset_osd got=%b exp=0", osd); end
        @(posedge clk); #1;
    endtask

    task automatic test_host_write();
        logic [7:0]  fixed[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        logic [18:0] exp[$];
        wq.delete();
        host_byte(1'b1, 8'h23);
        for (int i = 0; i < 4; i++) begin
            host_byte(1'b0, fixed[i]);
            exp.push_back({3'd3, i[7:0], fixed[i]});
        end
        for (int it = 0; it < 3; it++) begin
            logic [2:0] l = 3'($urandom_range(0, 7));
            int         n = $urandom_range(1, 12);
            host_byte(1'b1, {5'b00100, l});
            for (int i = 0; i < n; i++) begin
                logic [7:0] d = 8'($urandom);
                host_byte(1'b0, d);
                exp.push_back({l, i[7:0], d});
            end
        end
        @(negedge clk);
        checks++;
        if (wq.size() != exp.size()) begin
            failures++; $display("FAIL host_write_count got=%0d exp=%0d", wq.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (wq[i] !== exp[i]) begin
                    failures++; $display("FAIL host_write[%0d] got addr=%h data=%h exp addr=%h data=%h",
                                         i, wq[i][18:8], wq[i][7:0], exp[i][18:8], exp[i][7:0]);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_enable();
        for (int it = 0; it < 6; it++) begin
            logic b = (it < 2) ? ~it[0] : 1'($urandom);
            bus.host_first = 1'b1;
            bus.host_data  = {7'b0100000, b};
            bus.host_valid = 1'b1;
            @(posedge clk); #1;
            bus.host_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (osd !== b) begin failures++; $display("FAIL enable_cmd%0d got=%b exp=%b", it, osd, b); end
            @(posedge clk); #1;
        end
        host_byte(1'b1, 8'h40);
        wq.delete();
        host_byte(1'b1, 8'h37);
        for (int i = 0; i < 3; i++) host_byte(1'b0, 8'($urandom));
        host_byte(1'b1, 8'h26);
        bus.host_ss = 1'b1;
        @(posedge clk); #1;
        bus.host_ss = 1'b0;
        host_byte(1'b0, 8'($urandom));
        @(negedge clk);
        checks++;
        if (wq.size() != 0) begin failures++; $display("FAIL skip_ss_writes got=%0d exp=0", wq.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        logic [7:0] cd[256];
        logic [7:0] hq[$];
        int  k = 0;
        bit  done = 0;
        int  ci = 0;
        int  hi = 0;
        for (int i = 0; i < 256; i++) cd[i] = 8'($urandom);
        host_byte(1'b1, 8'h25);
        wq.delete();
        bus.msg_line  = 4'd2;
        bus.msg_start = 1'b1;
        @(posedge clk); #1;
        bus.msg_start = 1'b0;
        bus.msg_valid = 1'b1;
        bus.msg_data  = cd[0];
        fork
            begin
                int budget = 0;
                bit acc;
                while (k < 256 && budget < 3000) begin
                    @(negedge clk);
                    acc = bus.msg_ready;
                    checks++;
                    if (bus.msg_ready !== ~bus.host_valid) begin
                        failures++; $display("FAIL ready_vs_host k=%0d got=%b exp=%b", k, bus.msg_ready, ~bus.host_valid);
                    end
                    @(posedge clk); #1;
                    budget++;
                    if (acc) begin
                        k++;
                        if (k < 256) bus.msg_data = cd[k];
                    end
                end
                bus.msg_valid = 1'b0;
                done = 1;
            end
            begin
                int c = 0;
                logic [7:0] hd;
                while (!done) begin
                    if (c % 8 == 7) begin
                        hd = 8'($urandom);
                        hq.push_back(hd);
                        bus.host_data  = hd;
                        bus.host_valid = 1'b1;
                    end else begin
                        bus.host_valid = 1'b0;
                    end
                    @(posedge clk); #1;
                    c++;
                end
                bus.host_valid = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        checks++;
        if (k != 256) begin failures++; $display("FAIL core_accepts got=%0d exp=256", k); end
        foreach (wq[i]) begin
            checks++;
            if (wq[i][18:16] == 3'd2 && ci < 256) begin
                if (wq[i] !== {3'd2, ci[7:0], cd[ci]}) begin
                    failures++; $display("FAIL core_write[%0d] got=%h exp=%h", ci, wq[i], {3'd2, ci[7:0], cd[ci]});
                end
                ci++;
            end else if (wq[i][18:16] == 3'd5 && hi < hq.size()) begin
                if (wq[i] !== {3'd5, hi[7:0], hq[hi]}) begin
                    failures++; $display("FAIL host_mix_write[%0d] got=%h exp=%h", hi, wq[i], {3'd5, hi[7:0], hq[hi]});
                end
                hi++;
            end else begin
                failures++; $display("FAIL stray_write got=%h exp=none", wq[i]);
            end
        end
        checks += 4;
        if (ci != 256) begin failures++; $display("FAIL core_write_count got=%0d exp=256", ci); end
        if (hi != hq.size()) begin failures++; $display("FAIL host_mix_count got=%0d exp=%0d", hi, hq.size()); end
        if (bus.msg_busy !== 1'b0) begin failures++; $display("FAIL busy_after_popup got=%b exp=0", bus.msg_busy); end
        if (osd !== 1'b1) begin failures++; $display("FAIL osd_after_popup got=%b exp=1", osd); end
        @(posedge clk); #1;
    endtask

    task automatic test_popup_timer();
        int left = 3;
        for (int e = 0; e < 4; e++) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1 vs = 1'b1;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1 vs = 1'b0;
            if (left > 0) left--;
            @(negedge clk);
            checks++;
            if (osd !== (left != 0)) begin failures++; $display("FAIL popup_frame%0d got=%b exp=%b", e, osd, left != 0); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap();
        logic [18:0] exp[$];
        wq.delete();
        host_byte(1'b1, 8'h21);
        for (int i = 0; i < 258; i++) begin
            logic [7:0] d = 8'($urandom);
            host_byte(1'b0, d);
            exp.push_back({3'd1, i[7:0], d});
        end
        @(negedge clk);
        checks++;
        if (wq.size() != 258) begin
            failures++; $display("FAIL wrap_count got=%0d exp=258", wq.size());
        end else begin
            for (int i = 0; i < 258; i++) begin
                checks++;
                if (wq[i] !== exp[i]) begin
                    failures++; $display("FAIL wrap_write[%0d] got=%h exp=%h", i, wq[i], exp[i]);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        host_byte(1'b1, 8'h41);
        bus.msg_line  = 4'd1;
        bus.msg_start = 1'b1;
        @(posedge clk); #1;
        bus.msg_start = 1'b0;
        bus.msg_valid = 1'b1;
        bus.msg_data  = 8'h5A;
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus.msg_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", bus.msg_busy); end
        if (osd !== 1'b0) begin failures++; $display("FAIL rst_mid_osd got=%b exp=0", osd); end
        if (bus.buf_we !== 1'b0) begin failures++; $display("FAIL rst_mid_we got=%b exp=0", bus.buf_we); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        wq.delete();
        repeat (10) @(posedge clk);
        #1 bus.msg_valid = 1'b0;
        @(negedge clk);
        checks += 3;
        if (wq.size() != 0) begin failures++; $display("FAIL rst_after_writes got=%0d exp=0", wq.size()); end
        if (bus.msg_busy !== 1'b0) begin failures++; $display("FAIL rst_after_busy got=%b exp=0", bus.msg_busy); end
        if (osd !== 1'b0) begin failures++; $display("FAIL rst_after_osd got=%b exp=0", osd); end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.host_ss    = 1'b0;
        bus.host_valid = 1'b0;
        bus.host_first = 1'b0;
        bus.host_data  = 8'd0;
        bus.msg_start  = 1'b0;
        bus.msg_line   = 4'd0;
        bus.msg_valid  = 1'b0;
        bus.msg_data   = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_host_write();
        test_enable();
        test_contention();
        test_popup_timer();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
